// File: rtl/clint_pkg.sv
// clint_pkg: shared constants, register selector type and the byte-merge
// helper for the core-local interruptor.
//   ClintMsipOff / ClintMtimecmpOff / ClintMtimeOff : register offsets
//   ClintMtimecmpRst                                : mtimecmp reset value
//   reg_sel_e                                       : decoded register target
//   byte_merge()                                    : strobe-controlled write merge
package clint_pkg;

    localparam logic [63:0] ClintMsipOff     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ClintMtimecmpOff = 64'h0000_0000_0000_4000;
    localparam logic [63:0] ClintMtimeOff    = 64'h0000_0000_0000_BFF8;
    localparam logic [63:0] ClintMtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME,
        REG_NONE
    } reg_sel_e;

    // Replace each byte of old_val whose strobe is set with the write byte.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides the core clock down to the mtime increment rate.
//   clk  : core clock
//   rst  : asynchronous active-low reset
//   tick : high on the cycle div_cnt == TICK_DIV-1 (every cycle when TICK_DIV=1)
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LastCnt = 16'(TICK_DIV - 1);

    logic [15:0] div_cnt;

    assign tick = (div_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor holding mtime, mtimecmp and msip behind a
// valid/ready slave port with a one-entry response buffer.
//   clk, rst                       : core clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake
//   req_we/addr/wdata/wstrb        : request payload (8-byte aligned)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata/rsp_err              : read data (0 for writes), unmapped flag
//   tmr_intr_ena                   : registered mtime >= mtimecmp
//   sft_intr_ena                   : registered msip[0]
module clint
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tmr_intr_ena,
    output logic        sft_intr_ena
);

    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;

    reg_sel_e    sel;
    logic        accept;
    logic        wr;
    logic [63:0] rd_data;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;
    logic        msip_next;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Buffer frees up in the same cycle it is drained.
    assign req_ready = !rsp_valid | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign wr        = accept & req_we;

    always_comb begin
        sel = REG_NONE;
        if (req_addr == BASE_ADDR + ClintMsipOff) begin
            sel = REG_MSIP;
        end else if (req_addr == BASE_ADDR + ClintMtimecmpOff) begin
            sel = REG_MTIMECMP;
        end else if (req_addr == BASE_ADDR + ClintMtimeOff) begin
            sel = REG_MTIME;
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            REG_MSIP:     rd_data = {63'd0, msip};
            REG_MTIMECMP: rd_data = mtimecmp;
            REG_MTIME:    rd_data = mtime;
            default:      rd_data = '0;
        endcase
    end

    // A software write to mtime overrides the tick; unwritten bytes keep
    // the old, non-incremented value.
    always_comb begin
        mtime_next    = tick ? mtime + 64'd1 : mtime;
        mtimecmp_next = mtimecmp;
        msip_next     = msip;
        if (wr) begin
            case (sel)
                REG_MSIP: begin
                    if (req_wstrb[0]) begin
                        msip_next = req_wdata[0];
                    end
                end
                REG_MTIMECMP: mtimecmp_next = byte_merge(mtimecmp, req_wdata, req_wstrb);
                REG_MTIME:    mtime_next    = byte_merge(mtime, req_wdata, req_wstrb);
                default: ;
            endcase
        end
    end

    // Register state and interrupt levels computed from post-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime        <= '0;
            mtimecmp     <= ClintMtimecmpRst;
            msip         <= 1'b0;
            tmr_intr_ena <= 1'b0;
            sft_intr_ena <= 1'b0;
        end else begin
            mtime        <= mtime_next;
            mtimecmp     <= mtimecmp_next;
            msip         <= msip_next;
            tmr_intr_ena <= (mtime_next >= mtimecmp_next);
            sft_intr_ena <= msip_next;
        end
    end

    // Response buffer: load on accept, hold until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 64'd0 : rd_data;
            rsp_err   <= (sel == REG_NONE);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
